// File: rtl/dht_pkg.sv
// dht_pkg: shared state encoding, reply length and sensor mode encodings for the DHT controller
package dht_pkg;

    localparam int REPLY_BITS = 40;

    typedef enum logic {
        MODE_DHT22 = 1'b0,
        MODE_DHT11 = 1'b1
    } dht_mode_t;

    typedef enum logic [3:0] {
        IDLE,
        INIT,
        REQUEST,
        RELEASE,
        ACK_LOW,
        ACK_HIGH,
        BIT_LOW,
        BIT_HIGH,
        DONE
    } dht_state_t;

endpackage

// File: rtl/dht_frame_rx.sv
// dht_frame_rx: measures each bit's high phase, shifts the decoded bits MSB-first
// into a 40-bit frame and checks the trailing checksum byte against the first four
module dht_frame_rx
    import dht_pkg::*;
#(
    parameter int BIT_THRESHOLD = 48,
    parameter int HCNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic                  clear,
    input  logic                  high_start,
    input  logic                  high_en,
    input  logic                  shift_en,
    output logic                  last_bit,
    output logic [REPLY_BITS-1:0] frame,
    output logic                  crc_match
);

    localparam int BC_W = $clog2(REPLY_BITS + 1);

    logic [HCNT_W-1:0] high_cnt;
    logic [BC_W-1:0]   bit_cnt;
    logic              bit_val;
    logic [7:0]        byte_sum;

    // High-phase length in ticks; restarts on every rising edge and sticks at its maximum
    always_ff @(posedge clk) begin
        if (!rst) begin
            high_cnt <= '0;
        end else if (high_start) begin
            high_cnt <= '0;
        end else if (high_en && tick && (high_cnt != '1)) begin
            high_cnt <= high_cnt + 1'b1;
        end
    end

    assign bit_val  = (high_cnt > HCNT_W'(BIT_THRESHOLD));
    assign last_bit = (bit_cnt == BC_W'(REPLY_BITS - 1));

    // Shift register and bit counter; cleared before every frame so a silent sensor reads as zeros
    always_ff @(posedge clk) begin
        if (!rst) begin
            frame   <= '0;
            bit_cnt <= '0;
        end else if (clear) begin
            frame   <= '0;
            bit_cnt <= '0;
        end else if (shift_en) begin
            frame   <= {frame[REPLY_BITS-2:0], bit_val};
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    // Checksum is the 8-bit wrapping sum of the four data bytes
    always_comb begin
        byte_sum  = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
        crc_match = (byte_sum == frame[7:0]);
    end

endmodule

// File: rtl/dht_multi_cntrl.sv
// dht_multi_cntrl: on start, polls each single-wire DHT11/DHT22 bus in turn and
// reports one result (or a watchdog abort) per channel
module dht_multi_cntrl
    import dht_pkg::*;
#(
    parameter int CHANNELS           = 2,
    parameter int DIVIDER            = 100,
    parameter int INIT_TIME          = 1_000_000,
    parameter int REQUEST_TIME       = 1100,
    parameter int REQUEST_TIME_DHT11 = 20000,
    parameter int TIMEOUT            = 200,
    parameter int BIT_THRESHOLD      = 48,
    localparam int CH_W              = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                mode,
    output logic                busy,
    output logic [CH_W-1:0]     result_ch,
    output logic [15:0]         humidity,
    output logic [15:0]         temperature,
    output logic [7:0]          checksum,
    output logic                crc_ok,
    output logic                timeout_err,
    output logic                valid,
    inout  wire  [CHANNELS-1:0] data
);

    localparam int              DIV_W   = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);

    logic [DIV_W-1:0]      div_cnt;
    logic                  tick;
    logic [CHANNELS-1:0]   sync_q1;
    logic [CHANNELS-1:0]   sync_q2;
    logic                  line_prev;
    logic                  line_cur;
    logic                  fall;
    logic                  rise;
    dht_state_t            state;
    dht_state_t            next_state;
    logic [CH_W-1:0]       channel;
    logic [CH_W-1:0]       ch_next;
    dht_mode_t             mode_latched;
    logic [31:0]           state_ticks;
    logic [31:0]           req_last;
    logic                  tmo;
    logic                  frame_clear;
    logic                  high_start;
    logic                  shift_en;
    logic                  timeout_set;
    logic                  timeout_hit;
    logic                  last_bit;
    logic [REPLY_BITS-1:0] frame;
    logic                  crc_match;

    // Free-running divider; tick marks the last clk of every DIVIDER-cycle period
    always_ff @(posedge clk) begin
        if (!rst) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_W'(DIVIDER - 1)) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign tick = (div_cnt == DIV_W'(DIVIDER - 1));

    // Two-stage synchronizer on every bus; idle lines are pulled high
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q1 <= '1;
            sync_q2 <= '1;
        end else begin
            sync_q1 <= data;
            sync_q2 <= sync_q1;
        end
    end

    // Edge history follows the channel selected for next cycle, so a switch never shows a false edge
    always_ff @(posedge clk) begin
        if (!rst) begin
            line_prev <= 1'b1;
        end else begin
            line_prev <= sync_q2[ch_next];
        end
    end

    assign line_cur = sync_q2[channel];
    assign fall     = line_prev & ~line_cur;
    assign rise     = ~line_prev & line_cur;

    // Tick count inside the current state, zeroed on every state change
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_ticks <= '0;
        end else if (next_state != state) begin
            state_ticks <= '0;
        end else if (tick && (state_ticks != '1)) begin
            state_ticks <= state_ticks + 32'd1;
        end
    end

    assign req_last = (mode_latched == MODE_DHT11) ? 32'(REQUEST_TIME_DHT11 - 1) : 32'(REQUEST_TIME - 1);
    assign tmo      = (state_ticks > 32'(TIMEOUT));
    assign busy     = (state != IDLE);

    // State, channel pointer, latched mode and the abort flag for the current frame
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            channel      <= '0;
            mode_latched <= MODE_DHT22;
            timeout_hit  <= 1'b0;
        end else begin
            state   <= next_state;
            channel <= ch_next;
            if ((state == IDLE) && start) begin
                mode_latched <= dht_mode_t'(mode);
            end
            if (frame_clear) begin
                timeout_hit <= 1'b0;
            end else if (timeout_set) begin
                timeout_hit <= 1'b1;
            end
        end
    end

    // Next-state logic; in the edge-wait states an edge takes priority over the watchdog
    always_comb begin
        next_state  = state;
        ch_next     = channel;
        frame_clear = 1'b0;
        high_start  = 1'b0;
        shift_en    = 1'b0;
        timeout_set = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state  = INIT;
                    ch_next     = '0;
                    frame_clear = 1'b1;
                end
            end
            INIT: begin
                if (tick && (state_ticks == 32'(INIT_TIME - 1))) begin
                    next_state = REQUEST;
                end
            end
            REQUEST: begin
                if (tick && (state_ticks == req_last)) begin
                    next_state = RELEASE;
                end
            end
            RELEASE: begin
                if (fall) begin
                    next_state = ACK_LOW;
                end else if (tmo) begin
                    next_state  = DONE;
                    timeout_set = 1'b1;
                end
            end
            ACK_LOW: begin
                if (rise) begin
                    next_state = ACK_HIGH;
                end else if (tmo) begin
                    next_state  = DONE;
                    timeout_set = 1'b1;
                end
            end
            ACK_HIGH: begin
                if (fall) begin
                    next_state = BIT_LOW;
                end else if (tmo) begin
                    next_state  = DONE;
                    timeout_set = 1'b1;
                end
            end
            BIT_LOW: begin
                if (rise) begin
                    next_state = BIT_HIGH;
                    high_start = 1'b1;
                end else if (tmo) begin
                    next_state  = DONE;
                    timeout_set = 1'b1;
                end
            end
            BIT_HIGH: begin
                if (fall) begin
                    shift_en   = 1'b1;
                    next_state = last_bit ? DONE : BIT_LOW;
                end else if (tmo) begin
                    next_state  = DONE;
                    timeout_set = 1'b1;
                end
            end
            DONE: begin
                if (channel != LAST_CH) begin
                    ch_next     = channel + 1'b1;
                    frame_clear = 1'b1;
                    next_state  = INIT;
                end else begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    dht_frame_rx #(
        .BIT_THRESHOLD (BIT_THRESHOLD)
    ) u_frame_rx (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .clear      (frame_clear),
        .high_start (high_start),
        .high_en    (state == BIT_HIGH),
        .shift_en   (shift_en),
        .last_bit   (last_bit),
        .frame      (frame),
        .crc_match  (crc_match)
    );

    // Result registers load in DONE and hold until the next DONE; valid pulses once per result
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid       <= 1'b0;
            result_ch   <= '0;
            humidity    <= '0;
            temperature <= '0;
            checksum    <= '0;
            crc_ok      <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            valid <= (state == DONE);
            if (state == DONE) begin
                result_ch   <= channel;
                humidity    <= frame[39:24];
                temperature <= frame[23:8];
                checksum    <= frame[7:0];
                crc_ok      <= crc_match & ~timeout_hit;
                timeout_err <= timeout_hit;
            end
        end
    end

    // Open-drain drivers: only the selected bus is pulled low, and only while requesting
    for (genvar g = 0; g < CHANNELS; g++) begin : g_drv
        assign data[g] = ((state == REQUEST) && (channel == CH_W'(g))) ? 1'b0 : 1'bz;
    end

endmodule

// File: tb/tb_dht_multi_cntrl.sv
// tb_dht_multi_cntrl: sensor models on two buses, a table of scan vectors and a result scoreboard
module tb_dht_multi_cntrl;

    localparam int CHANNELS           = 2;
    localparam int DIVIDER            = 4;
    localparam int INIT_TIME          = 10;
    localparam int REQUEST_TIME       = 5;
    localparam int REQUEST_TIME_DHT11 = 18;
    localparam int TIMEOUT            = 20;
    localparam int BIT_THRESHOLD      = 4;

    localparam logic [39:0] FRAME_A = 40'h02_8C_01_5F_EE;
    localparam logic [39:0] FRAME_B = 40'h02_8C_01_5F_EF;
    localparam logic [39:0] FRAME_C = 40'h01_90_00_FA_8B;
    localparam logic [39:0] FRAME_D = 40'hFF_FF_FF_FF_FC;
    localparam logic [39:0] FRAME_E = 40'h00_00_00_00_00;

    typedef struct packed {
        logic [0:0]  ch;
        logic [15:0] hum;
        logic [15:0] temp;
        logic [7:0]  cks;
        logic        crc;
        logic        to;
        logic        bsy;
        logic        chk_data;
    } exp_t;

    typedef struct {
        logic        mode;
        logic        present0;
        logic [39:0] frame0;
        logic        present1;
        logic [39:0] frame1;
        logic        extra_start;
        int          req_clk;
        exp_t        exp0;
        exp_t        exp1;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic        busy;
    logic [0:0]  result_ch;
    logic [15:0] humidity;
    logic [15:0] temperature;
    logic [7:0]  checksum;
    logic        crc_ok;
    logic        timeout_err;
    logic        valid;
    wire  [1:0]  bus;
    logic [1:0]  sensor_low = 2'b00;
    logic [1:0]  dut_low;

    exp_t exp_q[$];
    exp_t mon_e;
    vec_t vecs[4];
    int   n_vec = 0;
    int   n_miss = 0;
    int   foreign_drive = 0;
    int   active_ch = -1;
    logic prev_valid = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_bus
        pullup (bus[g]);
        assign bus[g]     = sensor_low[g] ? 1'b0 : 1'bz;
        assign dut_low[g] = (bus[g] === 1'b0) && !sensor_low[g];
    end

    dht_multi_cntrl #(
        .CHANNELS           (CHANNELS),
        .DIVIDER            (DIVIDER),
        .INIT_TIME          (INIT_TIME),
        .REQUEST_TIME       (REQUEST_TIME),
        .REQUEST_TIME_DHT11 (REQUEST_TIME_DHT11),
        .TIMEOUT            (TIMEOUT),
        .BIT_THRESHOLD      (BIT_THRESHOLD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .mode        (mode),
        .busy        (busy),
        .result_ch   (result_ch),
        .humidity    (humidity),
        .temperature (temperature),
        .checksum    (checksum),
        .crc_ok      (crc_ok),
        .timeout_err (timeout_err),
        .valid       (valid),
        .data        (bus)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_miss++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic exp_t mk_exp(input logic ch, input logic [39:0] frame, input logic crc,
                                    input logic to, input logic bsy);
        exp_t e;
        e.ch       = ch;
        e.hum      = frame[39:24];
        e.temp     = frame[23:8];
        e.cks      = frame[7:0];
        e.crc      = crc;
        e.to       = to;
        e.bsy      = bsy;
        e.chk_data = !to;
        return e;
    endfunction

    function automatic vec_t mk_vec(input logic md, input logic p0, input logic [39:0] f0,
                                    input logic p1, input logic [39:0] f1, input logic xs,
                                    input int req, input exp_t e0, input exp_t e1);
        vec_t v;
        v.mode        = md;
        v.present0    = p0;
        v.frame0      = f0;
        v.present1    = p1;
        v.frame1      = f1;
        v.extra_start = xs;
        v.req_clk     = req;
        v.exp0        = e0;
        v.exp1        = e1;
        return v;
    endfunction

    // Scoreboard: each valid pulse is matched against the oldest queued expectation
    always @(negedge clk) begin
        if (prev_valid) begin
            checkOutput("valid_width", 32'(valid), 32'd0);
        end
        prev_valid = valid;
        if (valid) begin
            checkOutput("valid_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                checkOutput("result_ch", 32'(result_ch), 32'(mon_e.ch));
                if (mon_e.chk_data) begin
                    checkOutput("humidity", 32'(humidity), 32'(mon_e.hum));
                    checkOutput("temperature", 32'(temperature), 32'(mon_e.temp));
                    checkOutput("checksum", 32'(checksum), 32'(mon_e.cks));
                end
                checkOutput("crc_ok", 32'(crc_ok), 32'(mon_e.crc));
                checkOutput("timeout_err", 32'(timeout_err), 32'(mon_e.to));
                checkOutput("busy_at_valid", 32'(busy), 32'(mon_e.bsy));
            end
        end
        for (int g = 0; g < CHANNELS; g++) begin
            if (dut_low[g] && (g != active_ch)) begin
                foreign_drive++;
            end
        end
    end

    // Sensor model for one channel: measure the request pulse, then answer with a frame unless silent
    task automatic serveChannel(input int ch, input logic present, input logic [39:0] frame, input int req_clk);
        int guard;
        int low_len;
        guard = 0;
        while (!dut_low[ch] && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("request_seen", 32'(dut_low[ch]), 32'd1);
        if (!dut_low[ch]) begin
            return;
        end
        low_len = 0;
        while (dut_low[ch] && low_len < 1000) begin
            low_len++;
            @(negedge clk);
        end
        checkOutput("request_len", 32'(low_len), 32'(req_clk));
        if (present) begin
            repeat (8) @(negedge clk);
            sensor_low[ch] = 1'b1;
            repeat (16) @(negedge clk);
            sensor_low[ch] = 1'b0;
            repeat (16) @(negedge clk);
            for (int i = 39; i >= 0; i--) begin
                sensor_low[ch] = 1'b1;
                repeat (12) @(negedge clk);
                sensor_low[ch] = 1'b0;
                repeat (frame[i] ? 28 : 8) @(negedge clk);
            end
            sensor_low[ch] = 1'b1;
            repeat (12) @(negedge clk);
            sensor_low[ch] = 1'b0;
        end
    endtask

    // One full two-channel scan driven from a table row
    task automatic applyStimulus(input vec_t v);
        int guard;
        int busy_cycles;
        exp_q.push_back(v.exp0);
        exp_q.push_back(v.exp1);
        active_ch = 0;
        @(negedge clk);
        start = 1'b1;
        mode  = v.mode;
        @(negedge clk);
        start = 1'b0;
        mode  = ~v.mode;
        if (v.extra_start) begin
            repeat (5) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        serveChannel(0, v.present0, v.frame0, v.req_clk);
        active_ch = 1;
        serveChannel(1, v.present1, v.frame1, v.req_clk);
        guard = 0;
        while ((exp_q.size() != 0 || busy) && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("scan_finished", 32'(guard < 3000), 32'd1);
        exp_q.delete();
        active_ch = -1;
        if (v.extra_start) begin
            busy_cycles = 0;
            repeat (150) begin
                @(negedge clk);
                if (busy) busy_cycles++;
            end
            checkOutput("no_rescan", 32'(busy_cycles), 32'd0);
        end
    endtask

    initial begin
        int guard;
        int idle_bad;

        vecs[0] = mk_vec(1'b0, 1'b1, FRAME_A, 1'b0, FRAME_E, 1'b0, 20,
                         mk_exp(1'b0, FRAME_A, 1'b1, 1'b0, 1'b1), mk_exp(1'b1, FRAME_E, 1'b0, 1'b1, 1'b0));
        vecs[1] = mk_vec(1'b0, 1'b1, FRAME_B, 1'b1, FRAME_C, 1'b0, 20,
                         mk_exp(1'b0, FRAME_B, 1'b0, 1'b0, 1'b1), mk_exp(1'b1, FRAME_C, 1'b1, 1'b0, 1'b0));
        vecs[2] = mk_vec(1'b1, 1'b1, FRAME_D, 1'b1, FRAME_E, 1'b1, 72,
                         mk_exp(1'b0, FRAME_D, 1'b1, 1'b0, 1'b1), mk_exp(1'b1, FRAME_E, 1'b1, 1'b0, 1'b0));
        vecs[3] = mk_vec(1'b0, 1'b0, FRAME_E, 1'b1, FRAME_A, 1'b0, 20,
                         mk_exp(1'b0, FRAME_E, 1'b0, 1'b1, 1'b1), mk_exp(1'b1, FRAME_A, 1'b1, 1'b0, 1'b0));

        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_valid", 32'(valid), 32'd0);
        checkOutput("rst_crc_ok", 32'(crc_ok), 32'd0);
        checkOutput("rst_timeout_err", 32'(timeout_err), 32'd0);
        checkOutput("rst_humidity", 32'(humidity), 32'd0);
        checkOutput("rst_bus", 32'(bus), 32'd3);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            $display("[TB] vector %0d", i);
            applyStimulus(vecs[i]);
        end

        $display("[TB] reset during request");
        active_ch = 0;
        @(negedge clk);
        start = 1'b1;
        mode  = 1'b0;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (!dut_low[0] && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("rst_req_seen", 32'(dut_low[0]), 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_line0_released", 32'(bus[0] === 1'b1), 32'd1);
        checkOutput("rst_mid_busy", 32'(busy), 32'd0);
        checkOutput("rst_mid_valid", 32'(valid), 32'd0);
        checkOutput("rst_mid_crc_ok", 32'(crc_ok), 32'd0);
        checkOutput("rst_mid_timeout_err", 32'(timeout_err), 32'd0);
        checkOutput("rst_mid_result_ch", 32'(result_ch), 32'd0);
        checkOutput("rst_mid_humidity", 32'(humidity), 32'd0);
        checkOutput("rst_mid_temperature", 32'(temperature), 32'd0);
        checkOutput("rst_mid_checksum", 32'(checksum), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        idle_bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (busy || (dut_low != 2'b00)) idle_bad++;
        end
        checkOutput("idle_after_rst", 32'(idle_bad), 32'd0);
        active_ch = -1;

        checkOutput("foreign_drive", 32'(foreign_drive), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    // Global bound so a stuck design cannot hang the run
    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/dht_multi_cntrl.md
DHT_MULTI_CNTRL -- requirements
Module: dht_multi_cntrl

Interface
REQ-001 SHALL have parameter CHANNELS, default 2: number of independent single-wire sensor buses, 1..16.
REQ-002 SHALL have parameter DIVIDER, default 100: clk cycles per time tick (1 us at 100 MHz).
REQ-003 SHALL have parameter INIT_TIME, default 1_000_000: ticks the bus is released before a request.
REQ-004 SHALL have parameter REQUEST_TIME, default 1100: low-drive ticks in DHT22 mode.
REQ-005 SHALL have parameter REQUEST_TIME_DHT11, default 20000: low-drive ticks in DHT11 mode.
REQ-006 SHALL have parameter TIMEOUT, default 200: maximum ticks allowed in any wait-for-edge state.
REQ-007 SHALL have parameter BIT_THRESHOLD, default 48: a high-phase length in ticks above this value decodes as 1.
REQ-008 SHALL have the following ports:
- clk  in  1  the single clock
- rst  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; scans channels 0..CHANNELS-1
- mode  in  1  0 = DHT22/AM2302, 1 = DHT11; sampled on accepted start
- busy  out  1  scan in progress
- result_ch  out  clog2(CHANNELS) (min 1)  channel of the current result
- humidity  out  16  raw bytes 0..1
- temperature  out  16  raw bytes 2..3
- checksum  out  8  received byte 4
- crc_ok  out  1  byte sum mod 256 equals checksum
- timeout_err  out  1  frame aborted by the watchdog
- valid  out  1  one-cycle pulse; result fields are stable from this pulse until the next one
- data  inout  CHANNELS  open-drain buses: driven 0 or z only

Function
REQ-009 SHALL generate a tick pulse once every DIVIDER clk cycles; the tick counter runs freely.
REQ-010 SHALL pass each data line through a 2-FF synchronizer; only the line of the active channel feeds an edge detector; the edge-detector history SHALL be reloaded from the new line on each channel switch, with no edge reported.
REQ-011 FSM states SHALL be: IDLE, INIT, REQUEST, RELEASE, ACK_LOW, ACK_HIGH, BIT_LOW, BIT_HIGH, DONE.
REQ-012 IDLE -> INIT on start with channel = 0 and busy = 1; start SHALL be ignored while busy = 1.
REQ-013 INIT -> REQUEST after INIT_TIME ticks; the line is released.
REQ-014 REQUEST SHALL drive the active line low for REQUEST_TIME, or for REQUEST_TIME_DHT11 if mode latched 1, then go to RELEASE.
REQ-015 Edge transitions SHALL be: RELEASE -> ACK_LOW on fall; ACK_LOW -> ACK_HIGH on rise; ACK_HIGH -> BIT_LOW on fall; BIT_LOW -> BIT_HIGH on rise; BIT_HIGH -> BIT_LOW on fall.
REQ-016 In BIT_HIGH, ticks SHALL be counted with a saturating counter; on fall, bit = (count > BIT_THRESHOLD) is shifted MSB-first into a 40-bit register; after the 40th bit the FSM SHALL go to DONE instead of BIT_LOW.
REQ-017 A per-state tick counter SHALL clear on every state entry; in RELEASE/ACK_*/BIT_*, count > TIMEOUT SHALL go to DONE with timeout_err = 1.
REQ-018 DONE SHALL last 1 cycle, register the result fields, pulse valid, compute crc_ok = (b0+b1+b2+b3) mod 256 == b4 in 8-bit wrap arithmetic, and force crc_ok = 0 if timeout_err = 1.
REQ-019 After DONE, if channel < CHANNELS-1: increment channel, clear the shift register, go to INIT; otherwise go to IDLE with busy = 0 in the same cycle.
REQ-020 Only the active channel SHALL ever be driven low, and only in REQUEST; every other line SHALL be z.
REQ-021 If a fall and a timeout coincide, the edge SHALL win.

Reset
REQ-022 With rst = 0 at a clk edge, the block SHALL enter IDLE with busy, valid, crc_ok, timeout_err = 0; result_ch, humidity, temperature, checksum = 0; shift and tick counters cleared; all data lines z from the next cycle, including when reset arrives mid-REQUEST.

Structure
REQ-023 Package dht_pkg SHALL hold the FSM state enum, REPLY_BITS = 40, and the mode encodings.
REQ-024 Sub-module dht_frame_rx SHALL hold bit decoding, the high-phase counter, the 40-bit shifter and the checksum compare; the FSM and tick generator remain in the top module.

Verification (CHANNELS=2, DIVIDER=4, INIT_TIME=10, REQUEST_TIME=5, REQUEST_TIME_DHT11=18, TIMEOUT=20, BIT_THRESHOLD=4)
REQ-025 DHT22 mode, channel 0 model sends 0x02_8C_01_5F_EE with high phases of 2 ticks (0) and 7 ticks (1) -> valid with humidity=0x028C, temperature=0x015F, checksum=0xEE, crc_ok=1, result_ch=0.
REQ-026 Same frame with checksum 0xEF -> crc_ok=0, fields still reported.
REQ-027 Channel 1 silent -> line 1 low for exactly 20 clk, then valid with result_ch=1, timeout_err=1, crc_ok=0, busy falls; line 0 never driven during this.
REQ-028 mode=1 -> request low for exactly 72 clk; a start pulse during busy produces no second scan.
REQ-029 rst asserted mid-REQUEST -> line released next cycle, all outputs at reset values, busy=0.
